// File: rtl/filter_stream_ctrl.sv
// filter_stream_ctrl: streams one compressed filter from the filter buffer to a PE.
// A request (req_valid/req_k) is accepted only in IDLE. The filter start address
// is cfg_base_addr + req_k*cfg_num_words; cfg_num_words words are read one per
// cycle and delivered as beats through a 2-entry FIFO with valid/ready handshake.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_k/req_ready - filter request handshake
//   cfg_base_addr/num_words   - layer config, sampled when a request is accepted
//   mem_rd_en/addr/data       - buffer read port, data returns one cycle after en
//   wt_valid/data/last/ready  - weight beat stream to the PE
//   Stream_filter_finish      - one-cycle completion pulse
//   busy                      - high whenever not IDLE
module filter_stream_ctrl #(
  parameter int unsigned F      = 4,
  parameter int unsigned WT_W   = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned K_W    = 6,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [K_W-1:0]      req_k,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [CNT_W-1:0]    cfg_num_words,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [F*WT_W-1:0]   mem_rd_data,
  output logic                wt_valid,
  output logic [F*WT_W-1:0]   wt_data,
  output logic                wt_last,
  input  logic                wt_ready,
  output logic                Stream_filter_finish,
  output logic                busy
);

  localparam int unsigned DATA_W = F * WT_W;
  localparam int unsigned PROD_W = K_W + CNT_W;

  typedef enum logic [1:0] {IDLE, SETUP, STREAM, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    to_read_q, to_read_d;
  logic                rdv_q, rdv_d;             // read issued last cycle, data on bus now
  logic                rdv_last_q, rdv_last_d;   // that read is the filter's final word

  logic [1:0][DATA_W-1:0] fifo_data_q;
  logic [1:0]             fifo_last_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             cnt_q;

  logic                accept_c;
  logic                push_c;
  logic                pop_c;
  logic                issue_c;
  logic [2:0]          occ_c;
  logic [PROD_W-1:0]   prod_c;
  logic [ADDR_W-1:0]   start_c;

  // Filter start address; wraps modulo the buffer size.
  assign prod_c  = PROD_W'(req_k) * PROD_W'(cfg_num_words);
  assign start_c = cfg_base_addr + ADDR_W'(prod_c);

  assign accept_c = req_valid && (state_q == IDLE);
  assign push_c   = rdv_q;
  assign pop_c    = wt_valid && wt_ready;

  // Occupancy after this cycle's pop, plus the word arriving now; a new read
  // is only issued when its data is guaranteed a free FIFO slot.
  assign occ_c   = 3'(cnt_q) + 3'(rdv_q) - 3'(pop_c);
  assign issue_c = (state_q == STREAM) && (to_read_q != '0) && (occ_c < 3'd2);

  // Next-state and control logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    to_read_d  = to_read_q;
    rdv_d      = issue_c;
    rdv_last_d = issue_c && (to_read_q == CNT_W'(1));
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = SETUP;
          addr_d    = start_c;
          to_read_d = cfg_num_words;
        end
      end
      SETUP: begin
        state_d = (to_read_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (issue_c) begin
          addr_d    = addr_q + ADDR_W'(1);
          to_read_d = to_read_q - CNT_W'(1);
        end
        if (pop_c && wt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      to_read_q  <= '0;
      rdv_q      <= 1'b0;
      rdv_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      to_read_q  <= to_read_d;
      rdv_q      <= rdv_d;
      rdv_last_q <= rdv_last_d;
    end
  end

  // 2-entry output FIFO; push and pop may occur in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      if (push_c) begin
        fifo_data_q[wr_ptr_q] <= mem_rd_data;
        fifo_last_q[wr_ptr_q] <= rdv_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign req_ready            = (state_q == IDLE);
  assign busy                 = (state_q != IDLE);
  assign Stream_filter_finish = (state_q == DONE);
  assign mem_rd_en            = issue_c;
  assign mem_rd_addr          = addr_q;
  assign wt_valid             = (state_q == STREAM) && (cnt_q != 2'd0);
  assign wt_data              = fifo_data_q[rd_ptr_q];
  assign wt_last              = wt_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: doc/filter_stream_ctrl.md
FILTER_STREAM_CTRL -- requirements
Module: filter_stream_ctrl

Interface
REQ-001 SHALL have parameter F, 4, weights per beat.
REQ-002 SHALL have parameter WT_W, 8, bits per weight.
REQ-003 SHALL have parameter ADDR_W, 12, filter-buffer word address width.
REQ-004 SHALL have parameter K_W, 6, filter-index width.
REQ-005 SHALL have parameter CNT_W, 10, words-per-filter count width.
REQ-006 SHALL have port clk input 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst input 1: synchronous, active-high reset.
REQ-008 SHALL have port req_valid input 1: PE filter-stream request.
REQ-009 SHALL have port req_k input K_W: requested filter index.
REQ-010 SHALL have port req_ready output 1: request accepted when req_valid&&req_ready.
REQ-011 SHALL have port cfg_base_addr input ADDR_W: layer base word address, sampled at accept.
REQ-012 SHALL have port cfg_num_words input CNT_W: compressed words per filter, sampled at accept.
REQ-013 SHALL have port mem_rd_en output 1: buffer read strobe.
REQ-014 SHALL have port mem_rd_addr output ADDR_W: read address.
REQ-015 SHALL have port mem_rd_data input F*WT_W: read data, valid exactly one cycle after mem_rd_en.
REQ-016 SHALL have port wt_valid output 1, wt_data output F*WT_W, wt_last output 1: beat to PE.
REQ-017 SHALL have port wt_ready input 1: PE accepts beat when wt_valid&&wt_ready.
REQ-018 SHALL have port Stream_filter_finish output 1: one-cycle completion pulse to PE_CNTL.
REQ-019 SHALL have port busy output 1: high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, SETUP, STREAM, DONE.
REQ-021 SHALL assert req_ready only in IDLE; requests in other states are not accepted and not queued.
REQ-022 SHALL, on accept in cycle T, register start = cfg_base_addr + req_k*cfg_num_words (truncated to ADDR_W, wrap-around permitted) and remaining = cfg_num_words, entering SETUP at T+1.
REQ-023 SHALL go SETUP->DONE when remaining==0 (no reads, no beats), else SETUP->STREAM.
REQ-024 SHALL hold a 2-entry output FIFO; issue mem_rd_en in STREAM only when words still to read and (FIFO occupancy + reads in flight) < 2.
REQ-025 SHALL increment mem_rd_addr by 1 per issued read, starting at start; first read at T+2.
REQ-026 SHALL write mem_rd_data into the FIFO the cycle after each read, tagging the final word of the filter as last; first wt_valid at T+4 with wt_ready high.
REQ-027 SHALL drive wt_valid = FIFO non-empty, wt_data/wt_last from FIFO head; hold data stable while wt_valid&&!wt_ready.
REQ-028 SHALL support simultaneous FIFO write and pop in one cycle without loss; full throughput of one beat/cycle with wt_ready held high.
REQ-029 SHALL go STREAM->DONE on the cycle wt_last handshakes; DONE lasts one cycle with Stream_filter_finish=1, then IDLE.
REQ-030 SHALL never assert wt_valid outside STREAM and never drop wt_valid before handshake.

Reset
REQ-031 SHALL on rst: state IDLE, FIFO and in-flight count cleared, req_ready=1 (cycle after rst deasserts), mem_rd_en=0, mem_rd_addr=0, wt_valid=0, wt_data=0, wt_last=0, Stream_filter_finish=0, busy=0.
REQ-032 SHALL abandon any transfer on rst mid-stream; data returning from an earlier read is discarded.

Verification
REQ-033 base=0x100, num_words=3, k=2, wt_ready=1 -> reads 0x106,0x107,0x108 at T+2..T+4; beats T+4..T+6, wt_last at T+6; finish pulse T+7; req_ready T+8.
REQ-034 num_words=0 -> no mem_rd_en, no wt_valid; finish pulse at T+2.
REQ-035 num_words=5, wt_ready low for 6 cycles after first wt_valid -> at most 2 reads outstanding/buffered, wt_data stable, all 5 beats delivered in order.
REQ-036 base=0xFFE, k=0, num_words=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-037 req_valid held high during STREAM with different k -> ignored; accepted only after DONE returns to IDLE.
REQ-038 rst asserted mid-stream after 2 beats -> all outputs at reset values next cycle; new request then streams correctly from its start.
